// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, talks to instruction memory
// with a request/ready handshake, and feeds the IF/ID pipeline register.
// A one-entry buffer catches data that arrives while the pipeline is stalled,
// and a discard state swallows the response to a request that was
// redirected away while still outstanding.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcPrime,
  input  logic        pcSrcD,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] pcPlus4F,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic        imemWait
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  fetchState_t stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] bufInstrReg, bufInstrNext;
  logic [31:0] bufPcPlus4Reg, bufPcPlus4Next;
  logic [31:0] staleAddrReg, staleAddrNext;
  logic [31:0] instrDReg, instrDNext;
  logic [31:0] pcPlus4DReg, pcPlus4DNext;
  logic        validDReg, validDNext;

  logic redirect;
  logic pass;
  logic loadFetch;
  logic loadBuf;

  // A redirect only counts when decode is actually advancing. Data may only
  // move into IF/ID when neither fetch nor decode is stalled; otherwise it is
  // parked in the buffer so it is never lost or duplicated.
  assign redirect = pcSrcD & ~stallD;
  assign pass     = ~stallF & ~stallD;

  assign pcPlus4F = pcReg + 32'd4;
  assign imemReq  = ~reset & (stateReg != HOLD);
  assign imemAddr = (stateReg == DISCARD) ? staleAddrReg : {pcReg[31:2], 2'b00};
  assign imemWait = imemReq & ~imemReady;

  assign instrD   = instrDReg;
  assign pcPlus4D = pcPlus4DReg;
  assign validD   = validDReg;

  // Next-state, PC, buffer and IF/ID decisions.
  always_comb begin
    stateNext      = stateReg;
    pcNext         = pcReg;
    bufInstrNext   = bufInstrReg;
    bufPcPlus4Next = bufPcPlus4Reg;
    staleAddrNext  = staleAddrReg;
    loadFetch      = 1'b0;
    loadBuf        = 1'b0;
    instrDNext     = instrDReg;
    pcPlus4DNext   = pcPlus4DReg;
    validDNext     = validDReg;

    unique case (stateReg)
      FETCH: begin
        if (redirect) begin
          pcNext = pcPrime;
          if (!imemReady) begin
            // Request still in flight: remember its address and eat the reply.
            stateNext     = DISCARD;
            staleAddrNext = {pcReg[31:2], 2'b00};
          end
        end else if (imemReady) begin
          if (pass) begin
            pcNext    = pcPlus4F;
            loadFetch = 1'b1;
          end else begin
            stateNext      = HOLD;
            bufInstrNext   = imemRdata;
            bufPcPlus4Next = pcPlus4F;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pcNext    = pcPrime;
          stateNext = FETCH;
        end else if (pass) begin
          pcNext    = pcPlus4F;
          loadBuf   = 1'b1;
          stateNext = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) pcNext = pcPrime;
        if (imemReady) stateNext = FETCH;
      end
      default: stateNext = FETCH;
    endcase

    if (redirect || (flushD && !stallD)) begin
      instrDNext   = 32'd0;
      pcPlus4DNext = 32'd0;
      validDNext   = 1'b0;
    end else if (stallD) begin
      instrDNext   = instrDReg;
      pcPlus4DNext = pcPlus4DReg;
      validDNext   = validDReg;
    end else if (loadFetch) begin
      instrDNext   = imemRdata;
      pcPlus4DNext = pcPlus4F;
      validDNext   = 1'b1;
    end else if (loadBuf) begin
      instrDNext   = bufInstrReg;
      pcPlus4DNext = bufPcPlus4Reg;
      validDNext   = 1'b1;
    end else begin
      instrDNext   = 32'd0;
      pcPlus4DNext = 32'd0;
      validDNext   = 1'b0;
    end
  end

  // State, PC, buffer and IF/ID registers; reset aborts any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg      <= FETCH;
      pcReg         <= RESET_PC;
      bufInstrReg   <= 32'd0;
      bufPcPlus4Reg <= 32'd0;
      staleAddrReg  <= 32'd0;
      instrDReg     <= 32'd0;
      pcPlus4DReg   <= 32'd0;
      validDReg     <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      pcReg         <= pcNext;
      bufInstrReg   <= bufInstrNext;
      bufPcPlus4Reg <= bufPcPlus4Next;
      staleAddrReg  <= staleAddrNext;
      instrDReg     <= instrDNext;
      pcPlus4DReg   <= pcPlus4DNext;
      validDReg     <= validDNext;
    end
  end

endmodule
